// File: rtl/cntshift_frame_pkg.sv
// Shared FSM state type and counter sizing helper for the cntshift_frame receiver.
// The PAR state is only entered when CNTSHIFT_PARITY_EN is defined.
package cntshift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_e;

  // Bits needed to hold every count from 0 to width inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/cntshift_frame_if.sv
// Handshake bundle for cntshift_frame: control strobes and serial data in,
// parallel frame plus status flags out.
interface cntshift_frame_if
  import cntshift_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             start;
  logic             clr;
  logic             en;
  logic             si;
  logic             ready;
  logic [WIDTH-1:0] po;
  logic             valid;
  logic             busy;
  logic             co;
  logic             overrun;
  logic             parity_err;

  modport master (
    output start, clr, en, si, ready,
    input  po, valid, busy, co, overrun, parity_err
  );

  modport slave (
    input  start, clr, en, si, ready,
    output po, valid, busy, co, overrun, parity_err
  );
endinterface

// File: rtl/cntshift_counter.sv
// Data-bit counter for cntshift_frame: counts accepted strobes and flags the
// strobe that samples the last data bit; it clears itself on that strobe.
module cntshift_counter
  import cntshift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic co_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc;

  assign tc   = (cnt_q == CNT_W'(WIDTH - 1));
  assign co_o = en_i & tc;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cntshift_frame.sv
// Serial-to-parallel frame receiver with strobed bit sampling, valid/ready output and sticky overrun.
// Define CNTSHIFT_PARITY_EN to sample an extra even-parity bit after the data bits.
module cntshift_frame
  import cntshift_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  cntshift_frame_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, sreg_shifted;
  logic [WIDTH-1:0] commit_data;
  logic [WIDTH-1:0] po_q, po_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             shift_en, last_bit, commit, accept;

  // clr outranks start, and start outranks the bit strobe.
  assign shift_en = (state_q == SHIFT) && bus.en && !bus.start && !bus.clr;

  assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], bus.si}
                                  : {bus.si, sreg_q[WIDTH-1:1]};

  cntshift_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (bus.clr | bus.start),
    .en_i  (shift_en),
    .co_o  (last_bit)
  );

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    if (bus.clr) begin
      state_d = IDLE;
    end else if (bus.start) begin
      state_d = SHIFT;
    end else begin
      case (state_q)
        SHIFT: begin
          if (shift_en && last_bit) begin
`ifdef CNTSHIFT_PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
            commit  = 1'b1;
`endif
          end
        end
`ifdef CNTSHIFT_PARITY_EN
        PAR: begin
          if (bus.en) begin
            state_d = IDLE;
            commit  = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    sreg_d = sreg_q;
    if (bus.clr || bus.start) begin
      sreg_d = '0;
    end else if (shift_en) begin
      sreg_d = sreg_shifted;
    end
  end

`ifdef CNTSHIFT_PARITY_EN
  // Data bits are complete by PAR; the strobe there only carries the parity bit.
  assign commit_data = sreg_q;
`else
  assign commit_data = sreg_shifted;
`endif

  // A commit onto an unconsumed frame is dropped; one that meets a consume replaces it.
  assign accept = commit && !(valid_q && !bus.ready);

  always_comb begin
    po_d    = po_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (commit) begin
      if (accept) begin
        po_d    = commit_data;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && bus.ready) begin
      valid_d = 1'b0;
    end
    if (bus.clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      po_q    <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      po_q    <= po_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef CNTSHIFT_PARITY_EN
  logic perr_q, perr_d;

  // Even parity: data plus parity bit must hold an even number of ones.
  assign perr_d = accept ? ^{sreg_q, bus.si} : perr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign bus.parity_err = valid_q & perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.po      = po_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.co      = commit;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_cntshift_frame.sv
// Self-checking bench for cntshift_frame: MSB-first and LSB-first instances share
// stimulus and are compared every cycle against a frame-level reference model.
module tb_cntshift_frame;
  localparam int W = 8;
`ifdef CNTSHIFT_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int NB = W + PBITS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cntshift_frame_if #(.WIDTH(W)) if_m ();
  cntshift_frame_if #(.WIDTH(W)) if_l ();

  cntshift_frame #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(if_m));
  cntshift_frame #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(if_l));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: frame in progress and the bits collected so far.
  bit             m_busy;
  int             m_bits[$];
  logic [W-1:0]   m_po_m, m_po_l;
  bit             m_valid, m_ovr, m_perr;
  bit             co_seen;
  int             co_count;

  typedef struct {
    logic [W-1:0] seq;
    bit           pbit;
    logic [W-1:0] exp_m;
    logic [W-1:0] exp_l;
    bit           exp_perr;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit s, input bit c, input bit e, input bit d, input bit r);
    if_m.start = s; if_l.start = s;
    if_m.clr   = c; if_l.clr   = c;
    if_m.en    = e; if_l.en    = e;
    if_m.si    = d; if_l.si    = d;
    if_m.ready = r; if_l.ready = r;
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_bits.delete();
    m_po_m  = '0;
    m_po_l  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_perr  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_po_m"}, 32'(if_m.po), 32'd0);
    chk({tag, "_po_l"}, 32'(if_l.po), 32'd0);
    chk({tag, "_valid"}, 32'(if_m.valid), 32'd0);
    chk({tag, "_busy"}, 32'(if_m.busy), 32'd0);
    chk({tag, "_co"}, 32'(if_m.co), 32'd0);
    chk({tag, "_ovr"}, 32'(if_m.overrun), 32'd0);
    chk({tag, "_perr"}, 32'(if_m.parity_err), 32'd0);
  endtask

  // One clock cycle: drive at negedge, compare shortly after, then advance the model.
  task automatic step(input bit s, input bit c, input bit e, input bit d, input bit r);
    bit co_exp, commit;
    int am, al, ones;
    @(negedge clk);
    drive(s, c, e, d, r);
    #1;
    co_exp = (!c && !s && m_busy && e && m_bits.size() == NB - 1);
    chk("busy_m", 32'(if_m.busy), 32'(m_busy));
    chk("busy_l", 32'(if_l.busy), 32'(m_busy));
    chk("valid_m", 32'(if_m.valid), 32'(m_valid));
    chk("valid_l", 32'(if_l.valid), 32'(m_valid));
    chk("po_m", 32'(if_m.po), 32'(m_po_m));
    chk("po_l", 32'(if_l.po), 32'(m_po_l));
    chk("overrun", 32'(if_m.overrun), 32'(m_ovr));
    chk("parity_err", 32'(if_m.parity_err), 32'(m_valid & m_perr));
    chk("co_m", 32'(if_m.co), 32'(co_exp));
    chk("co_l", 32'(if_l.co), 32'(co_exp));
    co_seen = if_m.co;
    if (if_m.co) co_count++;

    commit = 1'b0;
    if (c) begin
      m_busy = 1'b0;
      m_bits.delete();
    end else if (s) begin
      m_busy = 1'b1;
      m_bits.delete();
    end else if (m_busy && e) begin
      m_bits.push_back(int'(d));
      if (m_bits.size() == NB) begin
        commit = 1'b1;
        m_busy = 1'b0;
      end
    end
    if (commit) begin
      if (m_valid && !r) begin
        m_ovr = 1'b1;
      end else begin
        am = 0; al = 0; ones = 0;
        for (int i = 0; i < W; i++) begin
          am = am * 2 + m_bits[i];
          al = al + (m_bits[i] << i);
        end
        for (int i = 0; i < NB; i++) ones += m_bits[i];
        m_po_m  = am[W-1:0];
        m_po_l  = al[W-1:0];
        m_perr  = (PBITS == 1) && ((ones % 2) == 1);
        m_valid = 1'b1;
      end
      m_bits.delete();
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    if (c) m_ovr = 1'b0;
  endtask

  task automatic feed_frame(input logic [W-1:0] seq, input bit pbit, input bit r);
    step(1'b1, 1'b0, 1'b0, 1'b0, r);
    for (int i = W - 1; i >= 0; i--) step(1'b0, 1'b0, 1'b1, seq[i], r);
    if (PBITS == 1) step(1'b0, 1'b0, 1'b1, pbit, r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] seq;
    tbl[0] = '{8'hB2, 1'b1, 8'hB2, 8'h4D, 1'b1};
    tbl[1] = '{8'hB2, 1'b0, 8'hB2, 8'h4D, 1'b0};
    tbl[2] = '{8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b0};
    tbl[3] = '{8'h01, 1'b1, 8'h01, 8'h80, 1'b0};
    tbl[4] = '{8'h11, 1'b1, 8'h11, 8'h88, 1'b1};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // en and start+clr while idle must not begin a frame
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("clr_over_start_busy", 32'(if_m.busy), 32'd0);

    for (int k = 0; k < 5; k++) begin
      feed_frame(tbl[k].seq, tbl[k].pbit, 1'b1);
      chk("tbl_co_last", 32'(co_seen), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("tbl_po_m", 32'(if_m.po), 32'(tbl[k].exp_m));
      chk("tbl_po_l", 32'(if_l.po), 32'(tbl[k].exp_l));
      chk("tbl_valid", 32'(if_m.valid), 32'd1);
      chk("tbl_perr", 32'(if_m.parity_err), 32'((PBITS == 1) ? tbl[k].exp_perr : 1'b0));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Two frames with no consumer: second dropped, overrun sticky until clr
    feed_frame(8'hB2, 1'b0, 1'b0);
    feed_frame(8'h11, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_po", 32'(if_m.po), 32'hB2);
    chk("ovr_flag", 32'(if_m.overrun), 32'd1);
    chk("ovr_valid", 32'(if_m.valid), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr_ovr", 32'(if_m.overrun), 32'd0);
    chk("clr_keeps_valid", 32'(if_m.valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("consumed_valid", 32'(if_m.valid), 32'd0);

    // Restart after three bits: one co for the whole sequence
    co_count = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    feed_frame(8'hFF, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("restart_co_count", 32'(co_count), 32'd1);
    chk("restart_po", 32'(if_m.po), 32'hFF);

    // Reset after five bits with valid and overrun set
    feed_frame(8'hA5, 1'b0, 1'b0);
    feed_frame(8'h3C, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    chk("midrst_no_valid", 32'(if_m.valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 29) == 0 && !m_busy) begin
        seq = W'($urandom);
        feed_frame(seq, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cntshift_frame.md
CNTSHIFT_FRAME -- requirements
Module: cntshift_frame

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of data bits per frame (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, where 1 means the first received bit lands in po[WIDTH-1] and 0 means it lands in po[0].
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begins a frame on the next cycle; a start while BUSY aborts and restarts the frame.
REQ-006 clr  input  1  synchronous clear of the FSM, counter and shift register; output register and valid are untouched.
REQ-007 en  input  1  bit strobe; si is sampled only when en=1 in SHIFT.
REQ-008 si  input  1  serial data in.
REQ-009 ready  input  1  consumer accepts po when valid=1.
REQ-010 po  output  WIDTH  parallel output register.
REQ-011 valid  output  1  po holds an unconsumed frame.
REQ-012 busy  output  1  FSM is not IDLE.
REQ-013 co  output  1  one-cycle pulse on the cycle the last bit of a frame is sampled.
REQ-014 overrun  output  1  sticky flag: a completed frame was dropped.
REQ-015 parity_err  output  1  parity result qualified by valid.

Function
REQ-016 FSM states SHALL be IDLE, SHIFT and PAR; PAR exists only when parity is compiled in.
REQ-017 IDLE→SHIFT SHALL occur on start=1; the counter is cleared to 0.
REQ-018 In SHIFT with en=1: shift si into the shift register per MSB_FIRST and increment the counter; with en=0: hold.
REQ-019 When en=1 and counter==WIDTH-1: co=1 that cycle; next state PAR if parity is enabled, else IDLE with a frame commit.
REQ-020 A frame commit SHALL copy the shift register to po and set valid on the following edge, giving 1 cycle latency from the last bit's edge to valid.
REQ-021 valid SHALL stay high until a cycle with valid=1 and ready=1, then clear unless a commit occurs in that same cycle.
REQ-022 Commit with valid=1 and ready=0: new frame dropped, po unchanged, overrun set.
REQ-023 Commit in the same cycle as valid&ready: po loads the new frame, valid stays 1, no overrun.
REQ-024 overrun SHALL clear only on reset or on clr=1.
REQ-025 start in SHIFT/PAR SHALL discard the partial frame, clear the counter and stay in SHIFT; start takes priority over en on that cycle.
REQ-026 clr SHALL take priority over start; it forces IDLE and counter=0.
REQ-027 The counter width SHALL be CNT_W = clog2(WIDTH+1); the counter never wraps, since it is cleared on commit, start and clr.
REQ-028 Shifting occurs only in SHIFT; en in IDLE SHALL have no effect.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, counter=0, shift register=0, po=0, valid=0, busy=0, co=0, overrun=0 and parity_err=0.
REQ-030 Reset mid-frame SHALL lose the partial frame; no commit occurs after release.

Configuration
REQ-031 Macro CNTSHIFT_PARITY_EN: when defined, one extra bit is sampled in PAR on en=1 after the data bits, even parity is checked over data+parity, and parity_err is registered with the commit.
REQ-032 With CNTSHIFT_PARITY_EN defined, co SHALL pulse on the parity bit instead of on the last data bit.
REQ-033 Without CNTSHIFT_PARITY_EN, the PAR state is not built and parity_err is tied to 0.

Structure
REQ-034 Package cntshift_pkg SHALL hold the state enum (IDLE, SHIFT, PAR) and the CNT_W helper function.
REQ-035 Sub-module cntshift_counter SHALL be a parametrised up-counter with clr, en and terminal-count compare that generates co.

Verification
REQ-036 WIDTH=8, MSB_FIRST=1: start, then bits 1,0,1,1,0,0,1,0 on consecutive en cycles → co at bit 8, po=8'hB2, valid next cycle.
REQ-037 Same bits with MSB_FIRST=0 → po=8'h4D.
REQ-038 Hold ready=0 and complete two frames (0xB2 then 0x11) → po stays 0xB2 and overrun=1.
REQ-039 start after 3 bits, then 8 bits of 0xFF → po=8'hFF and no extra co.
REQ-040 Assert rst_n=0 after bit 5 → all outputs 0 immediately, and valid never rises.
REQ-041 CNTSHIFT_PARITY_EN, data 0xB2 with parity bit 1 → parity_err=1; with parity bit 0 → parity_err=0.
